// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory array between the control unit (cu) and
// the program loader/debug port (ld). Accesses are serialized under a
// round-robin grant, held for WAIT_STATES extra cycles, and finished with a
// one-cycle done pulse to the owning port.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate requests on the next edge
// ACCESS | memory enabled with latched we/addr/wdata, counting wait states
// DONE   | completion pulse to the owner, captured read data visible
module memory_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  cu_req,
  input  logic                  cu_we,
  input  logic [ADDR_WIDTH-1:0] cu_addr,
  input  logic [DATA_WIDTH-1:0] cu_wdata,
  output logic                  cu_done,

  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_done,

  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  owner,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // A 3-bit down-counter covers the whole legal wait-state range of 0..7.
  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_STATES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             lat_we;

  logic             grant_en;
  logic             grant_port;
  logic             cnt_dec;
  logic             rd_capture;

  // Round-robin pick: a lone request wins outright, a tie goes to the port
  // that did not own the memory last.
  always_comb begin
    grant_port = owner;
    if (cu_req && ld_req) begin
      grant_port = ~owner;
    end else if (cu_req) begin
      grant_port = 1'b0;
    end else if (ld_req) begin
      grant_port = 1'b1;
    end
  end

  // Next-state and datapath controls; requests only matter while idle.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    cnt_dec    = 1'b0;
    rd_capture = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cu_req || ld_req) begin
          grant_en  = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt != '0) begin
          cnt_dec = 1'b1;
        end else begin
          rd_capture = ~lat_we;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant latch: the winner's command is frozen here so later changes on the
  // requester side cannot disturb an access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b1;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_en) begin
      owner     <= grant_port;
      lat_we    <= grant_port ? ld_we    : cu_we;
      mem_addr  <= grant_port ? ld_addr  : cu_addr;
      mem_wdata <= grant_port ? ld_wdata : cu_wdata;
    end
  end

  // Wait-state down-counter, loaded on grant and terminated at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (grant_en) begin
      wait_cnt <= CNT_LOAD;
    end else if (cnt_dec) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Read data register; writes leave the last read value in place.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_capture) begin
      rdata <= mem_rdata;
    end
  end

  // Outputs decoded purely from registered state, never from the requests.
  always_comb begin
    mem_en  = (state == ST_ACCESS);
    mem_we  = (state == ST_ACCESS) && lat_we;
    busy    = (state != ST_IDLE);
    cu_done = (state == ST_DONE) && !owner;
    ld_done = (state == ST_DONE) &&  owner;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two instances (WAIT_STATES=2 and 0) driven by
// directed and random requesters, checked against a transaction-timeline
// reference model of grants, wait states and completion cycles.
module tb_memory_arbiter;

  logic clock;
  logic reset;

  // Index [k][p]: k = instance (0: WAIT_STATES=2, 1: WAIT_STATES=0), p = port (0: cu, 1: ld).
  logic [1:0][1:0]       req;
  logic [1:0][1:0]       we;
  logic [1:0][1:0][15:0] addr;
  logic [1:0][1:0][7:0]  wdata;

  logic [1:0]        cu_done_o, ld_done_o, busy_o, owner_o, mem_en_o, mem_we_o;
  logic [1:0][7:0]   rdata_o, mem_wdata_o, mem_rdata_o;
  logic [1:0][15:0]  mem_addr_o;

  // Memories alias on the low address byte.
  logic [7:0] mem     [2][256];
  logic [7:0] ref_mem [2][256];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ws [2]   = '{2, 0};

  // Reference model: the access in flight is described by its grant edge.
  bit         act       [2];
  int         g         [2];
  int         a_port    [2];
  bit         a_we      [2];
  logic [15:0] a_addr   [2];
  logic [7:0] a_wdata   [2];
  int         own       [2];
  logic [7:0] exp_rdata [2];
  int         free_at   [2];
  bit         exp_done  [2][2];
  int         drv_mode  [2][2];   // 0 manual, 1 continuous reads, 2 random

  int done_port [$];
  int done_cyc  [$];
  int en_cnt, cd_cnt, ldd_cnt, we_cnt;

  assign mem_rdata_o = {mem[1][mem_addr_o[1][7:0]], mem[0][mem_addr_o[0][7:0]]};

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(2)) u_dut_ws2 (
    .clock(clock), .reset(reset),
    .cu_req(req[0][0]), .cu_we(we[0][0]), .cu_addr(addr[0][0]), .cu_wdata(wdata[0][0]),
    .cu_done(cu_done_o[0]),
    .ld_req(req[0][1]), .ld_we(we[0][1]), .ld_addr(addr[0][1]), .ld_wdata(wdata[0][1]),
    .ld_done(ld_done_o[0]),
    .rdata(rdata_o[0]), .busy(busy_o[0]), .owner(owner_o[0]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_o[0])
  );

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0)) u_dut_ws0 (
    .clock(clock), .reset(reset),
    .cu_req(req[1][0]), .cu_we(we[1][0]), .cu_addr(addr[1][0]), .cu_wdata(wdata[1][0]),
    .cu_done(cu_done_o[1]),
    .ld_req(req[1][1]), .ld_we(we[1][1]), .ld_addr(addr[1][1]), .ld_wdata(wdata[1][1]),
    .ld_done(ld_done_o[1]),
    .rdata(rdata_o[1]), .busy(busy_o[1]), .owner(owner_o[1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    return {8'($urandom), 8'($urandom_range(0, 15))};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k]       = 1'b0;
      own[k]       = 1;
      exp_rdata[k] = 8'h00;
      free_at[k]   = 0;
      exp_done[k][0] = 1'b0;
      exp_done[k][1] = 1'b0;
    end
  endtask

  // Advance the model to the edge just taken, using the request levels that
  // were stable across that edge.
  task automatic model_step(input int k);
    int p;
    if (!reset) return;
    if (act[k] && cyc == g[k] + ws[k] + 2) act[k] = 1'b0;
    if (!act[k] && cyc >= free_at[k]) begin
      p = -1;
      if (req[k][0] && req[k][1]) p = 1 - own[k];
      else if (req[k][0])         p = 0;
      else if (req[k][1])         p = 1;
      if (p >= 0) begin
        act[k]     = 1'b1;
        g[k]       = cyc;
        a_port[k]  = p;
        a_we[k]    = we[k][p];
        a_addr[k]  = addr[k][p];
        a_wdata[k] = wdata[k][p];
        own[k]     = p;
        free_at[k] = cyc + ws[k] + 3;
        if (we[k][p]) ref_mem[k][addr[k][p][7:0]] = wdata[k][p];
      end
    end
    if (act[k] && cyc == g[k] + ws[k] + 1 && !a_we[k])
      exp_rdata[k] = ref_mem[k][a_addr[k][7:0]];
  endtask

  task automatic check_outputs(input int k);
    bit in_acc, in_done;
    in_acc  = act[k] && cyc >= g[k] && cyc <= g[k] + ws[k];
    in_done = act[k] && cyc == g[k] + ws[k] + 1;
    exp_done[k][0] = in_done && a_port[k] == 0;
    exp_done[k][1] = in_done && a_port[k] == 1;
    check($sformatf("mem_en[%0d]", k),  32'(mem_en_o[k]),  32'(in_acc));
    check($sformatf("mem_we[%0d]", k),  32'(mem_we_o[k]),  32'(in_acc && a_we[k]));
    check($sformatf("busy[%0d]", k),    32'(busy_o[k]),    32'(in_acc || in_done));
    check($sformatf("cu_done[%0d]", k), 32'(cu_done_o[k]), 32'(exp_done[k][0]));
    check($sformatf("ld_done[%0d]", k), 32'(ld_done_o[k]), 32'(exp_done[k][1]));
    check($sformatf("owner[%0d]", k),   32'(owner_o[k]),   32'(own[k]));
    check($sformatf("rdata[%0d]", k),   32'(rdata_o[k]),   32'(exp_rdata[k]));
    if (in_acc)
      check($sformatf("mem_addr[%0d]", k), 32'(mem_addr_o[k]), 32'(a_addr[k]));
    if (in_acc && a_we[k])
      check($sformatf("mem_wdata[%0d]", k), 32'(mem_wdata_o[k]), 32'(a_wdata[k]));
  endtask

  // Requesters: drop req in the cycle done is due, otherwise follow the mode.
  task automatic drive(input int k);
    for (int p = 0; p < 2; p++) begin
      if (exp_done[k][p]) begin
        req[k][p] = 1'b0;
      end else if (drv_mode[k][p] == 1) begin
        if (!req[k][p]) begin
          req[k][p] = 1'b1; we[k][p] = 1'b0;
          addr[k][p] = rand_addr(); wdata[k][p] = 8'($urandom);
        end
      end else if (drv_mode[k][p] == 2) begin
        if (!req[k][p]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[k][p] = 1'b1; we[k][p] = 1'($urandom);
            addr[k][p] = rand_addr(); wdata[k][p] = 8'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          we[k][p] = 1'($urandom); addr[k][p] = rand_addr(); wdata[k][p] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic run_cycle();
    @(posedge clock);
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      drive(k);
      if (mem_en_o[k] && mem_we_o[k]) mem[k][mem_addr_o[k][7:0]] = mem_wdata_o[k];
    end
  endtask

  task automatic set_req(input int k, input int p, input logic w, input logic [15:0] a,
                         input logic [7:0] d);
    req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
  endtask

  initial begin
    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) drv_mode[k][p] = 0;
      for (int i = 0; i < 256; i++) begin
        mem[k][i]     = 8'($urandom);
        ref_mem[k][i] = mem[k][i];
      end
    end
    model_reset();

    // Reset values.
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_mem_en",    32'(mem_en_o[k]),    32'h0);
      check("rst_mem_we",    32'(mem_we_o[k]),    32'h0);
      check("rst_mem_addr",  32'(mem_addr_o[k]),  32'h0);
      check("rst_mem_wdata", 32'(mem_wdata_o[k]), 32'h0);
      check("rst_rdata",     32'(rdata_o[k]),     32'h0);
      check("rst_cu_done",   32'(cu_done_o[k]),   32'h0);
      check("rst_ld_done",   32'(ld_done_o[k]),   32'h0);
      check("rst_busy",      32'(busy_o[k]),      32'h0);
      check("rst_owner",     32'(owner_o[k]),     32'h1);
    end
    run_cycle();
    run_cycle();
    reset = 1'b1;

    // cu reads 0x1234, memory returns 0xA5.
    mem[0][8'h34] = 8'hA5; ref_mem[0][8'h34] = 8'hA5;
    set_req(0, 0, 1'b0, 16'h1234, 8'h00);
    en_cnt = 0; cd_cnt = 0; ldd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      en_cnt += int'(mem_en_o[0]); cd_cnt += int'(cu_done_o[0]); ldd_cnt += int'(ld_done_o[0]);
    end
    check("t1_en_cycles", 32'(en_cnt), 32'd3);
    check("t1_cu_done",   32'(cd_cnt), 32'd1);
    check("t1_ld_done",   32'(ldd_cnt), 32'd0);
    check("t1_rdata",     32'(rdata_o[0]), 32'hA5);

    // ld writes 0x5A to 0x0040; rdata keeps 0xA5.
    set_req(0, 1, 1'b1, 16'h0040, 8'h5A);
    we_cnt = 0; ldd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      we_cnt += int'(mem_en_o[0] && mem_we_o[0]); ldd_cnt += int'(ld_done_o[0]);
    end
    check("t2_we_cycles", 32'(we_cnt), 32'd3);
    check("t2_ld_done",   32'(ldd_cnt), 32'd1);
    check("t2_rdata",     32'(rdata_o[0]), 32'hA5);
    check("t2_mem",       32'(mem[0][8'h40]), 32'h5A);

    // Both ports request continuously: strict alternation, 5 cycles apart.
    set_req(0, 0, 1'b0, rand_addr(), 8'h00);
    set_req(0, 1, 1'b0, rand_addr(), 8'h00);
    drv_mode[0][0] = 1; drv_mode[0][1] = 1;
    for (int i = 0; i < 22; i++) begin
      run_cycle();
      if (cu_done_o[0]) begin done_port.push_back(0); done_cyc.push_back(cyc); end
      if (ld_done_o[0]) begin done_port.push_back(1); done_cyc.push_back(cyc); end
    end
    drv_mode[0][0] = 0; drv_mode[0][1] = 0;
    check("t3_done_count", 32'(done_port.size() >= 4), 32'd1);
    if (done_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_order", 32'(done_port[i]), 32'(i % 2));
        if (i > 0) check("t3_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd5);
      end
    end
    for (int i = 0; i < 15; i++) run_cycle();

    // Address change after grant has no effect.
    set_req(0, 0, 1'b0, 16'h0001, 8'h00);
    run_cycle();
    addr[0][0] = 16'hFFFF;
    check("t4_addr_grant", 32'(mem_addr_o[0]), 32'h0001);
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (mem_en_o[0]) check("t4_addr_hold", 32'(mem_addr_o[0]), 32'h0001);
    end

    // Reset midway through an access, then a normal access afterwards.
    set_req(0, 0, 1'b0, 16'h0010, 8'h00);
    run_cycle();
    run_cycle();
    #2 reset = 1'b0;
    #1;
    check("t5_mem_en",  32'(mem_en_o[0]),  32'h0);
    check("t5_busy",    32'(busy_o[0]),    32'h0);
    check("t5_cu_done", 32'(cu_done_o[0]), 32'h0);
    check("t5_rdata",   32'(rdata_o[0]),   32'h0);
    check("t5_owner",   32'(owner_o[0]),   32'h1);
    model_reset();
    req = '0;
    run_cycle();
    run_cycle();
    reset = 1'b1;
    set_req(0, 0, 1'b0, 16'h0020, 8'h00);
    cd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      cd_cnt += int'(cu_done_o[0]);
    end
    check("t5_after_done", 32'(cd_cnt), 32'd1);

    // WAIT_STATES=0: back-to-back cu reads, one mem_en cycle, 3 cycles apart.
    done_cyc.delete();
    en_cnt = 0;
    set_req(1, 0, 1'b0, rand_addr(), 8'h00);
    drv_mode[1][0] = 1;
    for (int i = 0; i < 16; i++) begin
      run_cycle();
      en_cnt += int'(mem_en_o[1]);
      if (cu_done_o[1]) done_cyc.push_back(cyc);
    end
    drv_mode[1][0] = 0;
    check("t6_done_count", 32'(done_cyc.size() >= 4), 32'd1);
    if (done_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        check("t6_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
    end
    check("t6_en_per_access", 32'(en_cnt - done_cyc.size() <= 1 && en_cnt >= done_cyc.size()), 32'd1);
    for (int i = 0; i < 6; i++) run_cycle();

    // Random traffic on both instances and both ports.
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) drv_mode[k][p] = 2;
    for (int i = 0; i < 1500; i++) run_cycle();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) drv_mode[k][p] = 0;
    for (int i = 0; i < 20; i++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
